// File: rtl/pwm_axil_slave.sv
// AXI4-Lite subordinate for the PWM register file: turns AXI transactions into
// single-cycle decoded write/read strobes; bad index or partial strobe -> SLVERR.
module pwm_axil_slave #(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int REG_WIDTH      = 16,
  parameter int NUM_CHANNELS   = 4,
  localparam int DEPTH          = 1 + 2*NUM_CHANNELS,
  localparam int REG_ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]                  s_axil_awprot,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]                  s_axil_arprot,
  input  logic                        s_axil_arvalid,
  output logic                        s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,
  output logic                        write_en,
  output logic [REG_ADDR_WIDTH-1:0]   write_addr,
  output logic [REG_WIDTH-1:0]        write_data,
  output logic                        read_en,
  output logic [REG_ADDR_WIDTH-1:0]   read_addr,
  input  logic [REG_WIDTH-1:0]        read_data,
  input  logic                        read_valid
);

  // state  | meaning
  // R_IDLE | waiting for AR; arready high once out of reset
  // R_READ | read_en to register file, capture read_data/read_valid
  // R_RESP | rvalid held with captured data until rready

  localparam int IDX_W      = AXI_ADDR_WIDTH - 2;
  localparam int STRB_W     = AXI_DATA_WIDTH / 8;
  localparam int REG_STRB_W = REG_WIDTH / 8;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} rstate_t;

  // Keeps every ready low while rst_n is asserted; readys rise on the first edge after release.
  logic rst_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  logic                   aw_held, w_held;
  logic [IDX_W-1:0]       aw_idx_q;
  logic [REG_WIDTH-1:0]   wdata_q;
  logic [REG_STRB_W-1:0]  wstrb_q;
  logic                   aw_take, w_take, wr_fire, wr_ok;
  logic [IDX_W-1:0]       cur_idx;
  logic [REG_WIDTH-1:0]   cur_wdata;
  logic [REG_STRB_W-1:0]  cur_wstrb;

  assign s_axil_awready = rst_done && !aw_held && !s_axil_bvalid;
  assign s_axil_wready  = rst_done && !w_held && !s_axil_bvalid;
  assign aw_take = s_axil_awvalid && s_axil_awready;
  assign w_take  = s_axil_wvalid && s_axil_wready;

  // A handshake completing this edge is used directly, so the strobe lands one cycle later.
  assign cur_idx   = aw_held ? aw_idx_q : s_axil_awaddr[AXI_ADDR_WIDTH-1:2];
  assign cur_wdata = w_held ? wdata_q : s_axil_wdata[REG_WIDTH-1:0];
  assign cur_wstrb = w_held ? wstrb_q : s_axil_wstrb[REG_STRB_W-1:0];
  assign wr_fire   = (aw_held || aw_take) && (w_held || w_take);
  assign wr_ok     = (cur_idx < DEPTH_IDX) && (&cur_wstrb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      write_en      <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
    end else begin
      write_en <= 1'b0;
      if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
        s_axil_bresp  <= RESP_OKAY;
      end
      if (wr_fire) begin
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        write_en      <= wr_ok;
        if (wr_ok) begin
          write_addr <= cur_idx[REG_ADDR_WIDTH-1:0];
          write_data <= cur_wdata;
        end
      end else begin
        if (aw_take) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_axil_awaddr[AXI_ADDR_WIDTH-1:2];
        end
        if (w_take) begin
          w_held  <= 1'b1;
          wdata_q <= s_axil_wdata[REG_WIDTH-1:0];
          wstrb_q <= s_axil_wstrb[REG_STRB_W-1:0];
        end
      end
    end
  end

  rstate_t          state, next_state;
  logic [IDX_W-1:0] ar_idx_q;
  logic             rd_in_range;

  assign rd_in_range = ar_idx_q < DEPTH_IDX;
  assign read_addr   = ar_idx_q[REG_ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= R_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state     = state;
    s_axil_arready = 1'b0;
    read_en        = 1'b0;
    s_axil_rvalid  = 1'b0;
    case (state)
      R_IDLE: begin
        s_axil_arready = rst_done;
        if (rst_done && s_axil_arvalid) next_state = R_READ;
      end
      R_READ: begin
        read_en    = 1'b1;
        next_state = R_RESP;
      end
      R_RESP: begin
        s_axil_rvalid = 1'b1;
        if (s_axil_rready) next_state = R_IDLE;
      end
      default: next_state = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_idx_q     <= '0;
      s_axil_rdata <= '0;
      s_axil_rresp <= RESP_OKAY;
    end else begin
      if (s_axil_arvalid && s_axil_arready)
        ar_idx_q <= s_axil_araddr[AXI_ADDR_WIDTH-1:2];
      if (state == R_READ) begin
        if (rd_in_range && read_valid) begin
          s_axil_rdata <= AXI_DATA_WIDTH'(read_data);
          s_axil_rresp <= RESP_OKAY;
        end else begin
          s_axil_rdata <= '0;
          s_axil_rresp <= RESP_SLVERR;
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0],
                         s_axil_wdata[AXI_DATA_WIDTH-1:REG_WIDTH], s_axil_wstrb[STRB_W-1:REG_STRB_W]};

endmodule

// File: tb/tb_pwm_axil_slave.sv
// Directed bench for pwm_axil_slave with a small behavioural register file.
module tb_pwm_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        write_en, read_en, read_valid;
  logic [3:0]  write_addr, read_addr;
  logic [15:0] write_data, read_data;

  logic [15:0] regs [0:8];
  int errors = 0;
  int checks = 0;
  int we_pulses = 0;

  always #5 clk = ~clk;

  pwm_axil_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid)
  );

  // Register file: combinational read, write takes effect at the end of the strobe cycle.
  assign read_valid = (read_addr < 4'd9);
  assign read_data  = read_valid ? regs[read_addr] : 16'h0;

  always @(posedge clk) begin
    if (write_en && write_addr < 4'd9) regs[write_addr] <= write_data;
    if (rst_n && write_en) we_pulses <= we_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_write_en"}, write_en, 0);
    check({tag, "_read_en"}, read_en, 0);
    check({tag, "_bresp"}, bresp, 0);
    check({tag, "_rresp"}, rresp, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_write_addr"}, write_addr, 0);
    check({tag, "_write_data"}, write_data, 0);
    check({tag, "_read_addr"}, read_addr, 0);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit ok, input int gap, input bit w_first, input int stall);
    logic [3:0] idx;
    idx = addr[5:2];
    bready = (stall == 0);
    check("wr_awready_idle", awready, 1);
    check("wr_wready_idle", wready, 1);
    if (gap == 0) begin
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end else if (w_first) begin
      wdata = data; wstrb = strb; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      for (int i = 0; i < gap - 1; i++) begin
        check("wr_wready_held", wready, 0);
        check("wr_we_early", write_en, 0);
        tick();
      end
      check("wr_wready_held", wready, 0);
      awaddr = addr; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
    end else begin
      awaddr = addr; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int i = 0; i < gap - 1; i++) begin
        check("wr_awready_held", awready, 0);
        check("wr_we_early", write_en, 0);
        tick();
      end
      check("wr_awready_held", awready, 0);
      wdata = data; wstrb = strb; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
    end
    check("wr_write_en", write_en, ok);
    if (ok) begin
      check("wr_write_addr", write_addr, idx);
      check("wr_write_data", write_data, data[15:0]);
    end
    check("wr_bvalid", bvalid, 1);
    check("wr_bresp", bresp, ok ? 2'b00 : 2'b10);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("wr_stall_bvalid", bvalid, 1);
      check("wr_stall_bresp", bresp, ok ? 2'b00 : 2'b10);
      check("wr_stall_awready", awready, 0);
      check("wr_stall_wready", wready, 0);
      check("wr_stall_we", write_en, 0);
    end
    bready = 1'b1;
    tick();
    check("wr_bvalid_done", bvalid, 0);
    check("wr_we_done", write_en, 0);
    check("wr_awready_back", awready, 1);
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data, input bit ok, input int stall);
    logic [3:0] idx;
    idx = addr[5:2];
    rready = (stall == 0);
    check("rd_arready_idle", arready, 1);
    araddr = addr; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rd_read_en", read_en, 1);
    check("rd_read_addr", read_addr, idx);
    check("rd_arready_busy", arready, 0);
    check("rd_rvalid_early", rvalid, 0);
    tick();
    check("rd_rvalid", rvalid, 1);
    check("rd_rdata", rdata, exp_data);
    check("rd_rresp", rresp, ok ? 2'b00 : 2'b10);
    check("rd_read_en_off", read_en, 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("rd_stall_rvalid", rvalid, 1);
      check("rd_stall_rdata", rdata, exp_data);
      check("rd_stall_rresp", rresp, ok ? 2'b00 : 2'b10);
      check("rd_stall_arready", arready, 0);
    end
    rready = 1'b1;
    tick();
    check("rd_rvalid_done", rvalid, 0);
    check("rd_arready_back", arready, 1);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) regs[i] = 16'h1000 + 16'(i);
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("post_reset_awready", awready, 1);
    check("post_reset_arready", arready, 1);

    axi_write(8'h20, 32'h0000_1234, 4'hF, 1'b1, 0, 1'b0, 0);
    axi_read(8'h20, 32'h0000_1234, 1'b1, 0);

    axi_write(8'h04, 32'h0000_00AB, 4'hF, 1'b1, 3, 1'b1, 0);
    axi_write(8'h08, 32'h0000_00CD, 4'hF, 1'b1, 3, 1'b0, 0);
    axi_read(8'h04, 32'h0000_00AB, 1'b1, 0);
    axi_read(8'h08, 32'h0000_00CD, 1'b1, 0);

    axi_write(8'h24, 32'h0000_BEEF, 4'hF, 1'b0, 0, 1'b0, 0);
    axi_write(8'h00, 32'h0000_7777, 4'h1, 1'b0, 0, 1'b0, 0);
    axi_read(8'h00, 32'h0000_1000, 1'b1, 0);
    axi_read(8'h24, 32'h0000_0000, 1'b0, 0);

    axi_write(8'h10, 32'hFFFF_4321, 4'h3, 1'b1, 0, 1'b0, 5);
    axi_read(8'h10, 32'h0000_4321, 1'b0 == 1'b1 ? 1'b0 : 1'b1, 5);

    // Write and read of the same index issued on the same edge.
    awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'h0000_5555; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 8'h0C; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("conc_write_en", write_en, 1);
    check("conc_read_en", read_en, 1);
    check("conc_write_addr", write_addr, 3);
    check("conc_read_addr", read_addr, 3);
    tick();
    check("conc_rvalid", rvalid, 1);
    check("conc_rdata_old", rdata, 32'h0000_1003);
    check("conc_bvalid_done", bvalid, 0);
    tick();
    check("conc_rvalid_done", rvalid, 0);
    axi_read(8'h0C, 32'h0000_5555, 1'b1, 0);

    // Reset between AW and W drops the held address.
    awaddr = 8'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("mid_awready_held", awready, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    axi_write(8'h18, 32'h0000_9999, 4'hF, 1'b1, 3, 1'b1, 0);
    axi_read(8'h14, 32'h0000_1005, 1'b1, 0);
    axi_read(8'h18, 32'h0000_9999, 1'b1, 0);

    check("total_write_pulses", we_pulses, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_axil_slave.md
# pwm_axil_slave

AXI4-Lite subordinate front end for the PWM generator: terminates the five AXI4-Lite channels from the system interconnect and converts each transaction into the single-cycle decoded write/read strobes consumed by the PWM register file (prescale at index 0, period/duty per channel at indices 1+2i / 2+2i). Write and read paths are independent FSMs. Out-of-range or partially-strobed accesses are rejected with SLVERR and never reach the register file.

## Interface
- AXI_ADDR_WIDTH, 8: AXI byte-address width.
- AXI_DATA_WIDTH, 32: AXI data width; must be ≥ REG_WIDTH.
- REG_WIDTH, 16: register file data width.
- NUM_CHANNELS, 4: PWM channels.
- DEPTH (localparam), 1+2*NUM_CHANNELS: number of registers.
- REG_ADDR_WIDTH (localparam), $clog2(DEPTH): register index width.
- Reset is rst_n, asynchronous, active-low; clock is clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- s_axil_awaddr  in  AXI_ADDR_WIDTH  write address; s_axil_awprot in 3, ignored
- s_axil_awvalid in 1 / s_axil_awready out 1  AW handshake
- s_axil_wdata  in  AXI_DATA_WIDTH  write data; s_axil_wstrb in AXI_DATA_WIDTH/8
- s_axil_wvalid in 1 / s_axil_wready out 1  W handshake
- s_axil_bresp  out  2  00 OKAY, 10 SLVERR; s_axil_bvalid out 1 / s_axil_bready in 1
- s_axil_araddr  in  AXI_ADDR_WIDTH  read address; s_axil_arprot in 3, ignored
- s_axil_arvalid in 1 / s_axil_arready out 1  AR handshake
- s_axil_rdata  out  AXI_DATA_WIDTH; s_axil_rresp out 2; s_axil_rvalid out 1 / s_axil_rready in 1
- write_en  out  1  one-cycle write strobe to register file
- write_addr  out  REG_ADDR_WIDTH; write_data out REG_WIDTH
- read_en  out  1  read strobe; read_addr out REG_ADDR_WIDTH
- read_data  in  REG_WIDTH  combinational read data from register file; read_valid in 1

## Operation
- Address decode: index = addr[AXI_ADDR_WIDTH-1:2]; addr[1:0] ignored. In range iff index < DEPTH.
- Write path: AW and W accepted independently, in either order or same cycle, each latched into a holding register with a held flag. awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
- When both held: issue write, clear both flags, raise bvalid. Write issued (write_en=1, write_addr=index, write_data=wdata[REG_WIDTH-1:0]) only if in range and wstrb[REG_WIDTH/8-1:0] all ones; else write_en stays 0 and bresp=SLVERR. Upper wdata/wstrb bits ignored.
- bvalid/bresp held stable until bready; no new AW/W accepted while bvalid=1.
- Read FSM: R_IDLE (arready=1) -> on arvalid, latch araddr -> R_READ (read_en=1, read_addr=index, capture read_data) -> R_RESP (rvalid=1) -> on rready -> R_IDLE.
- rdata = zero-extended captured read_data; rresp=OKAY if in range and read_valid=1, else rdata=0, rresp=SLVERR. read_en asserted in R_READ even when out of range (register file returns read_valid=0).
- rvalid/rdata/rresp stable until rready.

## Timing
- While rst_n low: all outputs 0 (readys, valids, write_en, read_en, resp, data, addresses). Readys rise on first clk edge after release. Reset mid-transaction discards all held requests and pending responses.
- Write: last of AW/W handshakes at edge N -> write_en and bvalid high in cycle N+1; write_en exactly one cycle; register file updates at end of N+1. bready already high -> next AW/W accepted in N+2.
- Read: AR handshake at edge N -> read_en in cycle N+1 -> rvalid in N+2. Minimum 3 cycles per read, arready low in R_READ/R_RESP.
- Simultaneous read and write to same index with write_en and read_en in same cycle: read returns pre-write value.
- Read and write channels never block each other.

## Test plan
- Write 0x20 data 0x0000_1234 strb 0xF, AW/W same cycle -> write_en one cycle later, write_addr=8, write_data=0x1234, bresp OKAY; read 0x20 -> rdata 0x0000_1234, rresp OKAY, rvalid 2 cycles after AR handshake.
- W 0x00AB three cycles before AW 0x04, then reverse order for 0x08 -> single write_en each, indices 1 and 2, data correct, wready low while w_held.
- Write 0x24 (index 9) and write 0x00 with strb 0x1 -> no write_en, bresp SLVERR; read 0x24 -> rdata 0, rresp SLVERR.
- bready held low 5 cycles -> bvalid/bresp stable, awready/wready low throughout; rready held low 5 cycles -> rvalid/rdata stable, arready low.
- Concurrent write 0x0C=0x5555 and read 0x0C with write_en and read_en coincident -> read returns old value; subsequent read returns 0x5555.
- Assert rst_n low between AW handshake and W -> all outputs 0; after release, lone W produces no write until a new AW arrives.
